// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default widths.
// Reused by the ROM and decoder so address widths stay in step.
package fetch_pkg;

    localparam int A  = 10;
    localparam int OW = 6;
    localparam int CW = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_next_pc.sv
// Combinational next-PC selection for the fetch stage.
// Priority: stall, halt, absolute branch, relative branch, increment.
module next_pc_logic #(
    parameter int A  = fetch_pkg::A,
    parameter int OW = fetch_pkg::OW
) (
    input  logic [A-1:0]  pc,
    input  logic          stall,
    input  logic          halt,
    input  logic          branch_abs_en,
    input  logic          branch_rel_en,
    input  logic          taken,
    input  logic [A-1:0]  target,
    input  logic [OW-1:0] offset,
    output logic [A-1:0]  next_pc,
    output logic          wrap
);

    logic [A-1:0] off_ext;
    logic [A:0]   inc;

    assign off_ext = A'($signed(offset));
    assign inc     = {1'b0, pc} + (A+1)'(1);

    always_comb begin
        next_pc = pc;
        wrap    = 1'b0;
        if (stall || halt) begin
            next_pc = pc;
        end else if (branch_abs_en && taken) begin
            next_pc = target;
        end else if (branch_rel_en && taken) begin
            // Relative wrap is modulo 2^A and is legal.
            next_pc = pc + off_ext;
        end else begin
            next_pc = inc[A-1:0];
            wrap    = inc[A];
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Program counter and fetch control: state, PC, sticky wrap
// flag and saturating run-cycle counter.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int A  = fetch_pkg::A,
    parameter int OW = fetch_pkg::OW,
    parameter int CW = fetch_pkg::CW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchAbsEn,
    input  logic          BranchRelEn,
    input  logic          Taken,
    input  logic [A-1:0]  Target,
    input  logic [OW-1:0] Offset,
    output logic [A-1:0]  ProgCtr,
    output logic          FetchValid,
    output logic          Done,
    output logic          WrapErr,
    output logic [CW-1:0] CycleCount
);

    fetch_state_t  state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic          wrap_q, wrap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [A-1:0]  nxt_pc;
    logic          nxt_wrap;

    next_pc_logic #(
        .A  (A),
        .OW (OW)
    ) u_next_pc (
        .pc            (pc_q),
        .stall         (Stall),
        .halt          (Halt),
        .branch_abs_en (BranchAbsEn),
        .branch_rel_en (BranchRelEn),
        .taken         (Taken),
        .target        (Target),
        .offset        (Offset),
        .next_pc       (nxt_pc),
        .wrap          (nxt_wrap)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = wrap_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    wrap_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                pc_d = nxt_pc;
                if (nxt_wrap) begin
                    wrap_d = 1'b1;
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!Stall && Halt) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ProgCtr    = pc_q;
    assign FetchValid = (state_q == RUN);
    assign Done       = (state_q == DONE);
    assign WrapErr    = wrap_q;
    assign CycleCount = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch, with a CW=4 copy
// sharing the inputs for counter saturation.
module tb_inst_fetch;

    localparam int A  = 10;
    localparam int OW = 6;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Reset, Start, Stall, Halt;
    logic          BranchAbsEn, BranchRelEn, Taken;
    logic [A-1:0]  Target;
    logic [OW-1:0] Offset;
    logic [A-1:0]  ProgCtr, pc_s;
    logic          FetchValid, Done, WrapErr;
    logic          valid_s, done_s, wrap_s;
    logic [CW-1:0] CycleCount;
    logic [3:0]    cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    inst_fetch #(.A(A), .OW(OW), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .Halt(Halt), .BranchAbsEn(BranchAbsEn),
        .BranchRelEn(BranchRelEn), .Taken(Taken),
        .Target(Target), .Offset(Offset), .ProgCtr(ProgCtr),
        .FetchValid(FetchValid), .Done(Done), .WrapErr(WrapErr),
        .CycleCount(CycleCount)
    );

    inst_fetch #(.A(A), .OW(OW), .CW(4)) dut_small (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .Halt(Halt), .BranchAbsEn(BranchAbsEn),
        .BranchRelEn(BranchRelEn), .Taken(Taken),
        .Target(Target), .Offset(Offset), .ProgCtr(pc_s),
        .FetchValid(valid_s), .Done(done_s), .WrapErr(wrap_s),
        .CycleCount(cnt_s)
    );

    typedef struct {
        logic          start, stall, halt, abs_en, rel_en, taken;
        logic [A-1:0]  target;
        logic [OW-1:0] offset;
        int            pc, valid, done, wrap, cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, sl, h, ab, rl, tk,
                       input int tgt, off,
                       input int pc, v, d, w, c);
        vec_t r;
        r.start = st; r.stall = sl; r.halt = h;
        r.abs_en = ab; r.rel_en = rl; r.taken = tk;
        r.target = A'(tgt); r.offset = OW'(off);
        r.pc = pc; r.valid = v; r.done = d; r.wrap = w; r.cnt = c;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Start = 0; Stall = 0; Halt = 0;
        BranchAbsEn = 0; BranchRelEn = 0; Taken = 0;
        Target = '0; Offset = '0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int pc, v, d, w, c);
        chk({tag, ".pc"}, int'(ProgCtr), pc);
        chk({tag, ".valid"}, int'(FetchValid), v);
        chk({tag, ".done"}, int'(Done), d);
        chk({tag, ".wrap"}, int'(WrapErr), w);
        chk({tag, ".cnt"}, int'(CycleCount), c);
    endtask

    initial begin
        //   st sl h ab rl tk  tgt   off   pc  v d w cnt
        add(1, 0, 0, 0, 0, 0,    0,   0,    0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,    0,   0,    1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,    0,   0,    2, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,    0,   0,    3, 1, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0,    0,   0,    4, 1, 0, 0, 4);
        add(0, 0, 0, 1, 0, 1,   12,   0,   12, 1, 0, 0, 5);
        add(0, 0, 0, 0, 1, 1,    0,  -3,    9, 1, 0, 0, 6);
        add(0, 0, 0, 0, 1, 0,    0,  -3,   10, 1, 0, 0, 7);
        add(0, 0, 0, 1, 0, 1,   20,   0,   20, 1, 0, 0, 8);
        add(0, 0, 0, 1, 1, 1,  100,   5,  100, 1, 0, 0, 9);
        add(1, 0, 0, 0, 0, 0,    0,   0,  101, 1, 0, 0, 10);
        add(0, 0, 0, 1, 0, 1,    7,   0,    7, 1, 0, 0, 11);
        add(0, 1, 1, 0, 0, 0,    0,   0,    7, 1, 0, 0, 12);
        add(0, 1, 1, 1, 0, 1,  200,   0,    7, 1, 0, 0, 13);
        add(0, 0, 1, 0, 0, 0,    0,   0,    7, 0, 1, 0, 14);
        add(0, 0, 0, 0, 0, 0,    0,   0,    7, 0, 1, 0, 14);
        add(0, 0, 0, 1, 0, 1,   50,   0,    7, 0, 1, 0, 14);
        add(1, 0, 0, 0, 0, 0,    0,   0,    0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 1020,   0, 1020, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1,    0,  10,    6, 1, 0, 0, 2);
        add(0, 0, 0, 1, 0, 1, 1022,   0, 1022, 1, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0,    0,   0, 1023, 1, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0,    0,   0,    0, 1, 0, 1, 5);
        add(0, 0, 0, 0, 0, 0,    0,   0,    1, 1, 0, 1, 6);
        add(0, 0, 0, 1, 0, 1,   30,   0,   30, 1, 0, 1, 7);

        idle_inputs();
        Reset = 1;
        step();
        Start = 1;
        step();
        chk_all("reset_with_start", 0, 0, 0, 0, 0);
        Reset = 0;
        Start = 0;
        step();
        chk_all("idle_hold", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            Start = vecs[i].start;
            Stall = vecs[i].stall;
            Halt = vecs[i].halt;
            BranchAbsEn = vecs[i].abs_en;
            BranchRelEn = vecs[i].rel_en;
            Taken = vecs[i].taken;
            Target = vecs[i].target;
            Offset = vecs[i].offset;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].pc,
                    vecs[i].valid, vecs[i].done,
                    vecs[i].wrap, vecs[i].cnt);
        end

        // Reset mid-RUN at PC 30 with Start also high.
        idle_inputs();
        Reset = 1;
        Start = 1;
        step();
        chk_all("reset_mid_run", 0, 0, 0, 0, 0);
        Reset = 0;
        Start = 0;
        step();
        chk_all("post_reset_idle", 0, 0, 0, 0, 0);

        // Saturation of the CW=4 copy over 20 run cycles.
        Start = 1;
        step();
        Start = 0;
        chk("sat_start", int'(cnt_s), 0);
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 14) chk("sat_14", int'(cnt_s), 14);
            if (n == 15) chk("sat_15", int'(cnt_s), 15);
            if (n == 16) chk("sat_16", int'(cnt_s), 15);
        end
        chk("sat_20", int'(cnt_s), 15);
        chk("wide_20", int'(CycleCount), 20);
        chk("sat_pc", int'(pc_s), 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Program-counter and fetch-control stage that sits directly upstream of the instruction ROM: it produces the registered address the ROM decodes combinationally. It sequences a program from address 0 after a Start request and applies taken absolute or relative branches from the decode/ALU stage. It stops on Halt and reports completion, a wrap error and a saturating run-cycle count for benchmarking.

## Interface
- A, 10, instruction address width; must match the ROM's address width.
- OW, 6, relative-branch offset width; two's complement.
- CW, 16, cycle-counter width.
- Clk  input  1  single clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high; dominates every other input.
- Start  input  1  request to begin or restart a program; honoured only in IDLE or DONE.
- Stall  input  1  hold the PC this cycle; the current instruction is not retired.
- Halt  input  1  the current instruction is the program terminator.
- BranchAbsEn  input  1  the current instruction is an absolute branch.
- BranchRelEn  input  1  the current instruction is a relative branch.
- Taken  input  1  branch condition flag from the ALU.
- Target  input  A  absolute branch destination.
- Offset  input  OW  signed relative displacement, applied to the current PC.
- ProgCtr  output  A  registered address driven to the ROM.
- FetchValid  output  1  high when the state is RUN.
- Done  output  1  high when the state is DONE.
- WrapErr  output  1  sticky flag; the PC incremented past 2^A-1.
- CycleCount  output  CW  RUN cycles since the last start; saturates at all-ones.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- Reset forces state=IDLE, ProgCtr=0, WrapErr=0 and CycleCount=0, so FetchValid=0 and Done=0.
- In IDLE or DONE, Start=1 moves the state to RUN and sets ProgCtr=0, WrapErr=0 and CycleCount=0.
- In RUN, Start is ignored.
- In RUN, priority is highest first:
  - Stall: ProgCtr holds; Halt, branch and Taken inputs are ignored; CycleCount still increments.
  - Halt: the state moves to DONE and ProgCtr holds the halting address.
  - BranchAbsEn && Taken: ProgCtr=Target.
  - BranchRelEn && Taken: ProgCtr = ProgCtr + sign_extend(Offset), modulo 2^A. This wrap is legal and does not set WrapErr.
  - Otherwise: ProgCtr = ProgCtr + 1.
- If BranchAbsEn and BranchRelEn are both high, the absolute branch wins.
- An enable with Taken=0 falls through to PC+1.
- When ProgCtr = 2^A-1 and the sequential increment is selected: ProgCtr wraps to 0, WrapErr is set and RUN continues.
- CycleCount increments once per RUN cycle (the cycle the Halt is accepted included) and holds at 2^CW-1.
- In DONE, ProgCtr, WrapErr and CycleCount hold until Start or Reset.

## Timing
- ProgCtr is a register. The ROM output for the current ProgCtr is valid in the same cycle, and every control input is sampled against that instruction.
- Next-PC decisions take effect at the following rising edge, so a taken branch costs no bubble.
- Start in IDLE at edge N gives FetchValid=1 and ProgCtr=0 from edge N+1 onward.
- Halt sampled at edge N gives Done=1 and FetchValid=0 from edge N+1 onward.
- Start and Reset in the same cycle: Reset wins.
- Reset mid-RUN returns the block to IDLE on the next edge; no partial update survives.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.

## Structure
- Shared package fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {IDLE, RUN, DONE};
  - default widths A, OW and CW as localparams, reused by the ROM and the decoder.
- Sub-module next_pc_logic is purely combinational.
  - Inputs: current PC, Stall, Halt, the branch enables, Taken, Target and Offset.
  - Outputs: next PC and a wrap indication.
- The top level holds the state register, the PC register, the sticky WrapErr flag and the saturating counter.

## Test plan
- Reset, then Start pulse, then 5 free-running cycles: ProgCtr reads 0,1,2,3,4 on successive cycles; FetchValid=1; CycleCount=5.
- At PC=4, BranchAbsEn=1, Taken=1, Target=12 → next ProgCtr=12. At PC=12, BranchRelEn=1, Taken=1, Offset=-3 → next ProgCtr=9. At PC=9, BranchRelEn=1, Taken=0 → next ProgCtr=10.
- Both branch enables high with Taken=1, Target=100, Offset=+5 at PC=20 → ProgCtr=100.
- At PC=7, Stall and Halt high together for 2 cycles, then Halt alone → PC stays 7 while stalled, then Done=1, FetchValid=0, ProgCtr=7. A later Start restarts at PC 0 with CycleCount cleared.
- At PC=1023 (A=10), sequential increment → ProgCtr=0 and WrapErr=1 stays set. A relative branch from 1020 with Offset=+10 → ProgCtr=6 and WrapErr is not set.
- Reset asserted mid-RUN at PC=30 → the next cycle is IDLE with ProgCtr=0. Start asserted in the same cycle as Reset is ignored. Start during RUN is ignored with no PC change. With CW=4, 20 RUN cycles → CycleCount holds at 15.
